// File: rtl/fif_rd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fif_rd_pkg                                                       |
// | Brief   : Shared defaults, types and credit helper for the FIFO read side. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fif_rd_pkg;

    localparam int C_DATA_WIDTH = 8;
    localparam int C_SKID_DEPTH = 2;

    typedef logic [C_DATA_WIDTH-1:0]              data_t;
    typedef logic [$clog2(C_SKID_DEPTH)-1:0]      ptr_t;
    typedef logic [$clog2(C_SKID_DEPTH+1)-1:0]    cnt_t;

    // True when one more read can be issued without overrunning the skid buffer.
    function automatic logic credit_avail(input int count, input logic inflight,
                                          input logic pop, input int depth);
        return (count + int'(inflight) - int'(pop)) < depth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fif_rd_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fif_rd_skid_buf                                                  |
// | Brief   : Small circular buffer absorbing the FIFO read latency.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fif_rd_skid_buf
    import fif_rd_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int SKID_DEPTH = C_SKID_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_push,
    input  logic [DATA_WIDTH-1:0]              i_push_data,
    input  logic                               i_pop,
    output logic [DATA_WIDTH-1:0]              o_data,
    output logic [$clog2(SKID_DEPTH+1)-1:0]    o_count,
    output logic                               o_empty
);

    localparam int C_PTR_W = $clog2(SKID_DEPTH);
    localparam int C_CNT_W = $clog2(SKID_DEPTH+1);

    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic [C_CNT_W-1:0]    r_count;

    // Entries are cleared on reset so the output reads zero until the first capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fif_rd_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fif_rd_streamer                                                  |
// | Brief   : FIFO read master presenting words as a valid/ready stream.       |
// |           Define FIF_RD_STATS_EN to add word and stall counters.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fif_rd_streamer
    import fif_rd_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int SKID_DEPTH = C_SKID_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIF_RD_STATS_EN
    ,
    output logic [31:0]           rd_word_cnt,
    output logic [31:0]           rd_stall_cnt
`endif
);

    localparam int C_CNT_W = $clog2(SKID_DEPTH+1);

    logic               r_inflight;
    logic               w_pop;
    logic               w_empty;
    logic [C_CNT_W-1:0] w_count;

    fif_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .SKID_DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (fifo_data),
        .i_pop       (w_pop),
        .o_data      (m_data),
        .o_count     (w_count),
        .o_empty     (w_empty)
    );

    assign m_valid = !w_empty;
    assign w_pop   = m_valid && m_ready;

    // The read strobe is held low throughout reset so nothing is pulled from the FIFO.
    assign fifo_rd_en = rst_n && !fifo_empty &&
                        credit_avail(int'(w_count), r_inflight, w_pop, SKID_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en;
        end
    end

`ifdef FIF_RD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_word_cnt  <= '0;
            rd_stall_cnt <= '0;
        end else begin
            if (w_pop) begin
                rd_word_cnt <= rd_word_cnt + 32'd1;
            end
            if (m_valid && !m_ready) begin
                rd_stall_cnt <= rd_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fif_rd_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fif_rd_streamer                                               |
// | Brief   : Directed self-checking bench with a behavioural FIFO model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fif_rd_streamer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_rd_en;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_empty = 1'b1;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
`ifdef FIF_RD_STATS_EN
    logic [31:0] rd_word_cnt;
    logic [31:0] rd_stall_cnt;
`endif

    fif_rd_streamer #(.DATA_WIDTH(8), .SKID_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIF_RD_STATS_EN
        ,
        .rd_word_cnt  (rd_word_cnt),
        .rd_stall_cnt (rd_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural synchronous FIFO: data_out one cycle after rd_en, registered empty.
    logic       push_en = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       flush = 1'b0;
    logic [7:0] fq[$];

    always @(posedge clk) begin
        if (flush) begin
            fq.delete();
        end else begin
            if (fifo_rd_en && fq.size() != 0) fifo_data <= fq.pop_front();
            if (push_en) fq.push_back(push_data);
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor, sampled mid-cycle.
    int         cyc = 0;
    logic [7:0] got[$];
    int         got_cyc[$];
    int         rden_cyc[$];
    int         underflow = 0;
    int         stab_viol = 0;
    int         stall_seen = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) begin
                rden_cyc.push_back(cyc);
                if (fifo_empty) underflow++;
            end
            if (m_valid && m_ready) begin
                got.push_back(m_data);
                got_cyc.push_back(cyc);
            end
            if (m_valid && !m_ready) stall_seen++;
            if (prev_stall && (!m_valid || m_data !== prev_data)) stab_viol++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end else begin
            prev_stall = 1'b0;
        end
        cyc++;
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        int quiet = 0;
        m_ready = 1'b1;
        while (quiet < 3 && n < 200) begin
            if (!m_valid && fifo_empty && !fifo_rd_en) quiet++;
            else quiet = 0;
            step();
            n++;
        end
        check(tag, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic wait_beats(input int base, input int want);
        int n = 0;
        while ((got.size() - base) < want && n < 200) begin
            step();
            n++;
        end
    endtask

    initial begin
        int g0, r0, s0, k, held;
        int pushed, n;
        logic [7:0] exp_q[$];
        logic [7:0] w;
`ifdef FIF_RD_STATS_EN
        logic [31:0] wc0, sc0;
`endif

        // Reset state
        #2;
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data",  32'(m_data),  32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Streaming 0x01..0x10 with m_ready held high
        m_ready = 1'b1;
        g0 = got.size();
        r0 = rden_cyc.size();
        for (int i = 1; i <= 16; i++) begin
            push_en = 1'b1;
            push_data = 8'(i);
            step();
        end
        push_en = 1'b0;
        wait_beats(g0, 16);
        check("stream_count", 32'(got.size() - g0), 32'd16);
        if (got.size() - g0 >= 16) begin
            check("stream_latency", 32'(got_cyc[g0] - rden_cyc[r0]), 32'd2);
            for (int i = 0; i < 16; i++) begin
                check("stream_data", 32'(got[g0+i]), 32'(i + 1));
                check("stream_gap", 32'(got_cyc[g0+i] - got_cyc[g0]), 32'(i));
            end
        end
        wait_idle("idle_after_stream");

        // Backpressure: 8 words, 10 stalled cycles
        m_ready = 1'b0;
        g0 = got.size();
        r0 = rden_cyc.size();
        s0 = stall_seen;
`ifdef FIF_RD_STATS_EN
        wc0 = rd_word_cnt;
        sc0 = rd_stall_cnt;
`endif
        k = 0;
        held = 0;
        while (held < 10 && k < 60) begin
            push_en = (k < 8);
            push_data = 8'h21 + 8'(k);
            if (m_valid) held++;
            step();
            k++;
        end
        push_en = 1'b0;
        check("bp_rd_pulses", 32'(rden_cyc.size() - r0), 32'd2);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_frozen", 32'(m_data), 32'h21);
        check("bp_stalls", 32'(stall_seen - s0), 32'd10);
        m_ready = 1'b1;
        wait_beats(g0, 8);
        check("bp_count", 32'(got.size() - g0), 32'd8);
        if (got.size() - g0 >= 8) begin
            for (int i = 0; i < 8; i++) check("bp_order", 32'(got[g0+i]), 32'(8'h21 + 8'(i)));
        end
        wait_idle("idle_after_bp");
`ifdef FIF_RD_STATS_EN
        check("stats_words", rd_word_cnt - wc0, 32'd8);
        check("stats_stalls", rd_stall_cnt - sc0, 32'd10);
`endif

        // Empty boundary: a single word
        m_ready = 1'b1;
        g0 = got.size();
        r0 = rden_cyc.size();
        push_en = 1'b1;
        push_data = 8'hA5;
        step();
        push_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("one_rd_pulse", 32'(rden_cyc.size() - r0), 32'd1);
        check("one_beat", 32'(got.size() - g0), 32'd1);
        if (got.size() > g0) check("one_data", 32'(got[g0]), 32'hA5);
        check("no_underflow", 32'(underflow), 32'd0);

        // Random backpressure, 1000 words
        g0 = got.size();
        pushed = 0;
        n = 0;
        while ((got.size() - g0) < 1000 && n < 20000) begin
            m_ready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                w = 8'($urandom);
                push_en = 1'b1;
                push_data = w;
                exp_q.push_back(w);
                pushed++;
            end else begin
                push_en = 1'b0;
            end
            step();
            n++;
        end
        push_en = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("rand_count", 32'(got.size() - g0), 32'd1000);
        if (got.size() - g0 == 1000) begin
            for (int i = 0; i < 1000; i++) check("rand_data", 32'(got[g0+i]), 32'(exp_q[i]));
        end
        check("rand_stable", 32'(stab_viol), 32'd0);
        check("rand_underflow", 32'(underflow), 32'd0);

        // Reset asserted mid-stream
        m_ready = 1'b1;
        push_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_data = 8'h40 + 8'(i);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("mid_rst_valid", 32'(m_valid), 32'd0);
        check("mid_rst_data",  32'(m_data),  32'd0);
`ifdef FIF_RD_STATS_EN
        check("mid_rst_words", rd_word_cnt, 32'd0);
`endif
        push_en = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        g0 = got.size();
        push_en = 1'b1;
        push_data = 8'h5A;
        step();
        push_en = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("post_rst_count", 32'(got.size() - g0), 32'd1);
        if (got.size() > g0) check("post_rst_data", 32'(got[g0]), 32'h5A);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
